// File: rtl/vlsu_meta_queue_if.sv
// rtl/vlsu_meta_queue_if.sv - enqueue, head/lookahead and retire signals of the VLSU metadata queue
interface vlsu_meta_queue_if #(
  parameter int  Depth      = 4,
  parameter type meta_glb_t = logic [7:0]
);
  localparam int CntW = $clog2(Depth + 1);

  logic            meta_valid_i;
  logic            meta_ready_o;
  meta_glb_t       meta_i;
  logic            head_valid_o;
  meta_glb_t       head_o;
  logic            next_valid_o;
  meta_glb_t       next_o;
  logic            head_done_i;
  logic            flush_i;
  logic [CntW-1:0] usage_o;
  logic            deq_err_o;

  // Control machine / data controller side
  modport master (
    output meta_valid_i, meta_i, head_done_i, flush_i,
    input  meta_ready_o, head_valid_o, head_o, next_valid_o, next_o, usage_o, deq_err_o
  );

  // Queue side
  modport slave (
    input  meta_valid_i, meta_i, head_done_i, flush_i,
    output meta_ready_o, head_valid_o, head_o, next_valid_o, next_o, usage_o, deq_err_o
  );
endinterface

// File: rtl/vlsu_meta_queue.sv
// rtl/vlsu_meta_queue.sv - circular buffer of in-flight VLSU global metadata with head and lookahead views
module vlsu_meta_queue #(
  parameter int  Depth      = 4,
  parameter type meta_glb_t = logic [7:0]
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  vlsu_meta_queue_if.slave q
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  meta_glb_t       mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] nx_ptr;
  logic [CntW-1:0] count;
  logic            deq_err;
  logic            enq_fire;
  logic            deq_fire;

  // Ready depends only on the registered count, so a retire in a full cycle cannot open the gate early.
  assign q.meta_ready_o = (count != CntW'(Depth));
  assign enq_fire       = q.meta_valid_i && q.meta_ready_o;
  // A retire against an empty queue never moves state, even if an enqueue lands in the same cycle.
  assign deq_fire       = q.head_done_i && (count != '0);

  // Lookahead pointer wraps on its own through the power-of-two pointer width.
  assign nx_ptr         = rd_ptr + PtrW'(1);

  assign q.head_o       = mem[rd_ptr];
  assign q.next_o       = mem[nx_ptr];
  assign q.head_valid_o = (count >= CntW'(1));
  assign q.next_valid_o = (count >= CntW'(2));
  assign q.usage_o      = count;
  assign q.deq_err_o    = deq_err;

  // Payload storage is not reset; the valid flags qualify what is visible.
  always_ff @(posedge clk_i) begin
    if (enq_fire && !q.flush_i) begin
      mem[wr_ptr] <= q.meta_i;
    end
  end

  // Pointer, occupancy and sticky error bookkeeping; flush discards same-cycle traffic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      deq_err <= 1'b0;
    end else if (q.flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      deq_err <= 1'b0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (deq_fire) begin
        rd_ptr <= nx_ptr;
      end
      if (q.head_done_i && (count == '0)) begin
        deq_err <= 1'b1;
      end
      unique case ({enq_fire, deq_fire})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_vlsu_meta_queue.sv
// tb/tb_vlsu_meta_queue.sv - scoreboard bench for vlsu_meta_queue against a queue-based reference
module tb_vlsu_meta_queue;
  localparam int DEPTH = 4;

  logic clk_i;
  logic rst_ni;

  vlsu_meta_queue_if #(.Depth(DEPTH), .meta_glb_t(logic [7:0])) bus ();

  vlsu_meta_queue #(.Depth(DEPTH), .meta_glb_t(logic [7:0])) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .q      (bus)
  );

  int unsigned n_cmp;
  int unsigned n_bad;
  logic [7:0]  exp_q [$];
  bit          exp_err;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain FIFO of accepted bytes plus an error flag, advanced at every edge.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else if (bus.flush_i) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else begin
      automatic bit was_full  = (exp_q.size() == DEPTH);
      automatic bit was_empty = (exp_q.size() == 0);
      if (bus.head_done_i) begin
        if (was_empty) exp_err = 1'b1;
        else void'(exp_q.pop_front());
      end
      if (bus.meta_valid_i && !was_full) exp_q.push_back(bus.meta_i);
    end
  end

  // Monitor: mid-cycle, compare every visible output with the reference contents.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("usage", int'(bus.usage_o), exp_q.size());
      chk("ready", int'(bus.meta_ready_o), int'(exp_q.size() != DEPTH));
      chk("head_valid", int'(bus.head_valid_o), int'(exp_q.size() >= 1));
      chk("next_valid", int'(bus.next_valid_o), int'(exp_q.size() >= 2));
      chk("deq_err", int'(bus.deq_err_o), int'(exp_err));
      if (exp_q.size() >= 1) chk("head", int'(bus.head_o), int'(exp_q[0]));
      if (exp_q.size() >= 2) chk("next", int'(bus.next_o), int'(exp_q[1]));
    end
  end

  task automatic drive(input bit v, input logic [7:0] d, input bit done, input bit fl);
    bus.meta_valid_i = v;
    bus.meta_i       = d;
    bus.head_done_i  = done;
    bus.flush_i      = fl;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic flush();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_ni = 1'b0;
    bus.meta_valid_i = 1'b0;
    bus.meta_i       = 8'h00;
    bus.head_done_i  = 1'b0;
    bus.flush_i      = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", int'(bus.meta_ready_o), 1);
    chk("rst_usage", int'(bus.usage_o), 0);
    chk("rst_head_valid", int'(bus.head_valid_o), 0);
    rst_ni = 1'b1;
    idle();

    // Single enqueue becomes visible one cycle later
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    idle();
    idle();

    // Fill, hold a fifth request, then retire once
    flush();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    repeat (3) drive(1'b1, 8'hA4, 1'b0, 1'b0);
    drive(1'b1, 8'hA4, 1'b1, 1'b0);
    drive(1'b1, 8'hA4, 1'b0, 1'b0);
    idle();

    // Retire advances head and lookahead
    flush();
    for (int i = 1; i <= 3; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle();

    // Steady occupancy of two across a pointer wrap
    flush();
    drive(1'b1, 8'h40, 1'b0, 1'b0);
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'h42 + 8'(i), 1'b1, 1'b0);
    idle();

    // Retire on empty is sticky until flush; enqueue+retire into empty also flags
    flush();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) idle();
    flush();
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    idle();
    flush();

    // Asynchronous reset mid-cycle with entries held
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
    idle();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_head_valid", int'(bus.head_valid_o), 0);
    chk("arst_usage", int'(bus.usage_o), 0);
    chk("arst_ready", int'(bus.meta_ready_o), 1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle();

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 45,
            $urandom_range(0, 199) < 3);
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vlsu_meta_queue.md
Name: vlsu_meta_queue

Overview:
Buffers global metadata (meta_glb_t) for in-flight VLSU requests between the control machine and the data controllers. It consumes the control machine's meta_ctrl valid/ready stream: its meta_ready_o drives meta_ctrl_ready_i, so the upstream meta_buf_full = !meta_ready_o. It presents the oldest entry (head) and the next-oldest (lookahead) to the data controllers. The head is retired on a completion pulse.

Parameters:
Depth, 4, number of entries; must be >= 2 and a power of two.
meta_glb_t, logic, global metadata struct, identical to the type used by the control machine.
CntW, $clog2(Depth+1), width of the occupancy count; derived, not overridden.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_ni  input  1  asynchronous active-low reset.
meta_valid_i  input  1  enqueue request; driven by meta_ctrl_valid_o.
meta_ready_o  output  1  enqueue accepted; drives meta_ctrl_ready_i.
meta_i  input  $bits(meta_glb_t)  metadata to enqueue.
head_valid_o  output  1  queue non-empty; head_o is meaningful.
head_o  output  $bits(meta_glb_t)  oldest entry.
next_valid_o  output  1  at least two entries held; next_o is meaningful.
next_o  output  $bits(meta_glb_t)  second-oldest entry.
head_done_i  input  1  single-cycle pulse; retire the head.
flush_i  input  1  synchronous clear of all entries.
usage_o  output  CntW  number of valid entries, 0..Depth.
deq_err_o  output  1  sticky error: head_done_i seen while empty.

Behaviour:
- Storage: Depth-entry register array, with wr_ptr and rd_ptr of width log2(Depth) that wrap modulo Depth. A count register of width CntW holds occupancy.
- Reset (rst_ni low, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, deq_err_o=0.
  - Outputs after reset: meta_ready_o=1, head_valid_o=0, next_valid_o=0, usage_o=0.
  - Storage contents are not reset; head_o and next_o are don't-care while their valid is low.
- Enqueue:
  - meta_ready_o = (count != Depth). It is a pure function of registered state, with no combinational path from head_done_i. While full, a same-cycle retire does not raise ready.
  - Enqueue fires when meta_valid_i && meta_ready_o. It writes mem[wr_ptr] <= meta_i and increments wr_ptr.
  - meta_valid_i and meta_i may change while ready is low; no stability assumption is placed on the upstream.
- Head and lookahead:
  - head_o = mem[rd_ptr]; next_o = mem[rd_ptr+1 mod Depth].
  - head_valid_o = (count >= 1); next_valid_o = (count >= 2).
  - Latency: an entry enqueued in cycle N is visible on head_o/head_valid_o in cycle N+1. There is no fall-through.
- Dequeue:
  - head_done_i with count >= 1 increments rd_ptr. In the next cycle the old next_o becomes head_o.
  - head_done_i with count == 0 is ignored for pointers and count, and sets deq_err_o=1.
  - deq_err_o clears only on reset or flush_i.
- Count update (per cycle): count += enq_fire - deq_fire, where deq_fire = head_done_i && count != 0.
  - Simultaneous enqueue and dequeue with 0 < count < Depth: count is unchanged and both pointers advance.
  - Enqueue into an empty queue plus head_done_i in the same cycle: deq_fire=0 (the new entry is not yet visible), count becomes 1, and deq_err_o is set.
- Flush:
  - flush_i=1 sets pointers=0, count=0, deq_err_o=0 at the next edge.
  - Any enqueue or dequeue in the same cycle is discarded.
  - meta_ready_o stays governed by pre-flush count during the flush cycle.
- usage_o = count, registered.
- Wrap-around: pointers roll from Depth-1 to 0 with no bubble. next_o wraps independently of head_o.
- Reset mid-operation: all in-flight entries are lost, and the state equals the post-reset state above. No output glitch ordering is guaranteed during reset assertion.

Test Plan:
1. Reset, then enqueue A (meta_i=0x11) in cycle 1. Required: cycle 2 has head_valid_o=1, head_o=0x11, next_valid_o=0, usage_o=1.
2. Depth=4: enqueue 4 entries back-to-back, holding meta_valid_i=1 for a fifth. Required: meta_ready_o=0 after the 4th; on a head_done_i pulse the 5th is accepted one cycle later, never in the same cycle.
3. Enqueue 0x01..0x03, then pulse head_done_i. Required: head_o goes 0x01→0x02, next_o 0x02→0x03, usage_o 3→2.
4. With usage_o=2, assert enqueue and head_done_i in the same cycle, repeated 10 cycles over a wrap. Required: usage_o stays 2 and head_o follows FIFO order.
5. Empty queue, pulse head_done_i. Required: deq_err_o=1, sticky, with usage_o=0; then flush_i. Required: deq_err_o=0.
6. Hold 3 entries and assert rst_ni=0 asynchronously mid-cycle. Required: immediately head_valid_o=0, usage_o=0, meta_ready_o=1.
